tag_responder_iterator: RTL

Sequencer that walks the responders of the CAPP tag register one at a time. On `start` it snapshots the tag vector, then presents the index and one-hot mask of the lowest-numbered set tag on a valid/ready handshake, clearing each entry as it is accepted, until none remain. It sits between the tag register and the instruction sequencer. It implements the "for each responder" loop and drives select-first write-back.

---
 rtl/tag_responder_iterator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tag_responder_iterator.sv
// Walks the set bits of a captured tag vector lowest-first over a valid/ready handshake; first responder one cycle after start, one per cycle while ready is high, held stable under backpressure.
// Optional build macro RESP_COUNT_EN adds o_resp_count, the popcount of the tags loaded at capture.
module tag_responder_iterator #(
  parameter int N     = 100,
  parameter int IDX_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [N-1:0]     i_tag_wires,
  input  logic             i_idx_ready,
  output logic             o_idx_valid,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_first_onehot,
  output logic             o_some_none,
  output logic             o_busy,
  output logic             o_done
`ifdef RESP_COUNT_EN
  ,
  output logic [IDX_W-1:0] o_resp_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [N-1:0]       r_snap;
  logic               r_some_none;
  logic               r_busy;
  logic               r_done;
  logic [N-1:0]       w_low_oh;
  logic [IDX_W-1:0]   w_low_idx;
  logic               w_any;
  logic               w_last;
  logic               w_hs;
  logic               w_scan_vld;

  // Two's-complement trick isolates the lowest set bit of the snapshot.
  assign w_low_oh = r_snap & (~r_snap + {{(N-1){1'b0}}, 1'b1});
  assign w_any    = |r_snap;
  assign w_last   = ~|(r_snap & ~w_low_oh);

  always_comb begin
    w_low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_snap[i]) begin
        w_low_idx = IDX_W'(i);
      end
    end
  end

  assign w_scan_vld = (r_state == S_SCAN) && w_any;
  // Abort wins over the handshake: the presented responder is not consumed.
  assign w_hs       = w_scan_vld && i_idx_ready && !i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) w_next = S_SCAN;
        S_SCAN: begin
          if (!w_any) begin
            w_next = S_DONE;
          end else if (w_hs && w_last) begin
            w_next = S_DONE;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_idx_valid    = w_scan_vld;
    o_idx          = '0;
    o_first_onehot = '0;
    if (w_scan_vld) begin
      o_idx          = w_low_idx;
      o_first_onehot = w_low_oh;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_snap      <= '0;
      r_some_none <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_next == S_SCAN);
      r_done <= (w_next == S_DONE);
      if (!i_abort) begin
        if ((r_state == S_IDLE) && i_start) begin
          r_snap      <= i_tag_wires;
          r_some_none <= |i_tag_wires;
        end else if (w_hs) begin
          r_snap <= r_snap & ~w_low_oh;
        end
      end
    end
  end

  assign o_some_none = r_some_none;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

`ifdef RESP_COUNT_EN
  logic [IDX_W-1:0] w_pop;
  logic [IDX_W-1:0] r_resp_count;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + IDX_W'(i_tag_wires[i]);
    end
  end

  // Survives abort; only a new capture or reset changes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_count <= '0;
    end else if (!i_abort && (r_state == S_IDLE) && i_start) begin
      r_resp_count <= w_pop;
    end
  end

  assign o_resp_count = r_resp_count;
`endif

endmodule
